// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Owns the fetch PC and drives the
// instruction memory address. Each returned instruction is queued together
// with its PC and presented to IF/ID over a valid/ready handshake. A redirect
// from a later stage flushes the queue and restarts fetch at the new target.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_instr_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];

    logic pop_s;
    logic push_s;
    logic full_s;
    logic [31:0] redirect_target_s;

    // Handshake qualifiers; valid comes only from registered occupancy so it
    // never depends combinationally on out_ready_i.
    assign out_valid_o = (count_q != {CW{1'b0}});
    assign full_s      = (count_q == CW'(DEPTH));
    assign pop_s       = out_valid_o & out_ready_i;
    // A pop while full frees the slot being written, so fetch never bubbles.
    assign push_s      = ~redirect_i & (~full_s | pop_s);

    // The low address bits of a redirect target are forced to zero.
    assign redirect_target_s = {redirect_pc_i[31:2], redirect_pc_i[1:0] & 2'b00};

    assign imem_addr_o = fetch_pc_q;
    assign out_pc_o    = pc_q[rd_ptr_q];
    assign out_instr_o = instr_q[rd_ptr_q];
    assign count_o     = count_q;

    // Next-state for fetch PC, pointers and occupancy (redirect flushes all).
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_target_s;
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d   = wr_ptr_q + PW'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                wr_ptr_d   = wr_ptr_q;
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage: cleared on reset, written with {PC, instruction} on push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'h0000_0000;
                instr_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_q[wr_ptr_q]    <= fetch_pc_q;
            instr_q[wr_ptr_q] <= imem_instr_i;
        end
    end

endmodule
